// File: rtl/pc_gen_hwl.sv
// Program-counter generator with nested zero-overhead hardware loops.
// Optional back-edge performance counter is enabled by defining HWL_PERF_CNT_EN.
module pc_gen_hwl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned HWL_LEVELS = 2,
    parameter int unsigned COUNT_W    = 16,
    localparam int unsigned LVL_W     = (HWL_LEVELS > 1) ? $clog2(HWL_LEVELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    input  logic                  hwl_set,
    input  logic [LVL_W-1:0]      hwl_level,
    input  logic [31:0]           hwl_start,
    input  logic [31:0]           hwl_end,
    input  logic [COUNT_W-1:0]    hwl_count,
    output logic [31:0]           pc,
    output logic                  pc_hwl_end_zero_flag,
    output logic [HWL_LEVELS-1:0] hwl_active,
    output logic                  hwl_backedge,
    output logic                  hwl_err,
    output logic [31:0]           hwl_iter_count
);

    localparam int unsigned PC_W = 32;

    logic [PC_W-1:0]                    pc_q, pc_d;
    logic [HWL_LEVELS-1:0][PC_W-1:0]    start_q, start_d, end_q, end_d;
    logic [HWL_LEVELS-1:0][COUNT_W-1:0] count_q, count_d;
    logic [HWL_LEVELS-1:0]              active_q, active_d, skip_q, skip_d;
    logic                               err_q;
    logic [PC_W-1:0]                    redir_pc;
    logic                               set_ok;
    logic                               backedge_c;
    logic                               found;
    logic                               zero_flag_c;

    assign redir_pc = redirect_pc & ~PC_W'(3);
    assign set_ok   = hwl_set && (hwl_end >= hwl_start)
                      && (hwl_start[1:0] == 2'b00) && (hwl_end[1:0] == 2'b00);

    // Next-PC selection, loop back-edge scan (inner level first) and loop-state update
    always_comb begin
        pc_d       = pc_q;
        start_d    = start_q;
        end_d      = end_q;
        count_d    = count_q;
        active_d   = active_q;
        skip_d     = skip_q;
        backedge_c = 1'b0;
        found      = 1'b0;
        if (!stall) begin
            if (redirect_valid) begin
                pc_d = redir_pc;
            end else begin
                pc_d = pc_q + PC_W'(4);
                for (int unsigned i = 0; i < HWL_LEVELS; i++) begin
                    // A level being re-armed this cycle neither back-edges nor retires
                    if (!found && active_q[i] && (pc_q == end_q[i])
                        && !(set_ok && (hwl_level == LVL_W'(i)))) begin
                        if (count_q[i] > COUNT_W'(1)) begin
                            count_d[i] = count_q[i] - COUNT_W'(1);
                            pc_d       = start_q[i];
                            backedge_c = 1'b1;
                            found      = 1'b1;
                        end else begin
                            count_d[i]  = '0;
                            active_d[i] = 1'b0;
                        end
                    end
                end
            end
            for (int unsigned i = 0; i < HWL_LEVELS; i++) begin
                if (skip_q[i] && ((pc_q == end_q[i])
                    || (redirect_valid && ((redir_pc < start_q[i]) || (redir_pc > end_q[i]))))) begin
                    skip_d[i] = 1'b0;
                end
            end
        end
        if (set_ok) begin
            for (int unsigned i = 0; i < HWL_LEVELS; i++) begin
                if (hwl_level == LVL_W'(i)) begin
                    start_d[i]  = hwl_start;
                    end_d[i]    = hwl_end;
                    count_d[i]  = hwl_count;
                    active_d[i] = (hwl_count != '0);
                    skip_d[i]   = (hwl_count == '0);
                end
            end
        end
    end

    // Fetch substitutes NOPs while pc walks a zero-trip body
    always_comb begin
        zero_flag_c = 1'b0;
        for (int unsigned i = 0; i < HWL_LEVELS; i++) begin
            if (skip_q[i] && (pc_q >= start_q[i]) && (pc_q <= end_q[i])) begin
                zero_flag_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            start_q  <= '0;
            end_q    <= '0;
            count_q  <= '0;
            active_q <= '0;
            skip_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            start_q  <= start_d;
            end_q    <= end_d;
            count_q  <= count_d;
            active_q <= active_d;
            skip_q   <= skip_d;
            if (hwl_set && !set_ok) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef HWL_PERF_CNT_EN
    logic [31:0] iter_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_q <= '0;
        end else if (backedge_c) begin
            iter_q <= iter_q + 32'd1;
        end
    end

    assign hwl_iter_count = iter_q;
`else
    assign hwl_iter_count = '0;
`endif

    assign pc                   = pc_q;
    assign pc_hwl_end_zero_flag = zero_flag_c;
    assign hwl_active           = active_q;
    assign hwl_backedge         = backedge_c;
    assign hwl_err              = err_q;

endmodule

// File: tb/tb_pc_gen_hwl.sv
// Directed bench for pc_gen_hwl: vector table for sequencing/redirect/stall, hand sequences for loops.
module tb_pc_gen_hwl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        hwl_set;
    logic [0:0]  hwl_level;
    logic [31:0] hwl_start;
    logic [31:0] hwl_end;
    logic [15:0] hwl_count;
    logic [31:0] pc;
    logic        pc_hwl_end_zero_flag;
    logic [1:0]  hwl_active;
    logic        hwl_backedge;
    logic        hwl_err;
    logic [31:0] hwl_iter_count;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef HWL_PERF_CNT_EN
    localparam logic [31:0] ITER_AFTER_A = 32'd2;
`else
    localparam logic [31:0] ITER_AFTER_A = 32'd0;
`endif

    pc_gen_hwl #(
        .RESET_PC   (32'h0000_0100),
        .HWL_LEVELS (2),
        .COUNT_W    (16)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .stall                (stall),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc),
        .hwl_set              (hwl_set),
        .hwl_level            (hwl_level),
        .hwl_start            (hwl_start),
        .hwl_end              (hwl_end),
        .hwl_count            (hwl_count),
        .pc                   (pc),
        .pc_hwl_end_zero_flag (pc_hwl_end_zero_flag),
        .hwl_active           (hwl_active),
        .hwl_backedge         (hwl_backedge),
        .hwl_err              (hwl_err),
        .hwl_iter_count       (hwl_iter_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic lvl, input logic [31:0] s, input logic [31:0] e, input logic [15:0] c);
        hwl_set   = 1'b1;
        hwl_level = lvl;
        hwl_start = s;
        hwl_end   = e;
        hwl_count = c;
    endtask

    initial begin
        logic [31:0] exp_a [13];
        logic [31:0] exp_d [5];
        int bcnt;
        int n30;
        int n2c;

        tbl[0] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0104};
        tbl[1] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0108};
        tbl[2] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_010C};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_010C};
        tbl[4] = '{1'b0, 1'b1, 32'h0000_0203, 32'h0000_0200};
        tbl[5] = '{1'b1, 1'b1, 32'h0000_0300, 32'h0000_0200};
        tbl[6] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        tbl[7] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[8] = '{1'b0, 1'b1, 32'h0000_0012, 32'h0000_0010};

        exp_a = '{32'h14, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h28, 32'h20, 32'h24,
                  32'h28, 32'h20, 32'h24, 32'h28, 32'h2C};
        exp_d = '{32'h60, 32'h64, 32'h60, 32'h64, 32'h68};

        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        hwl_set = 1'b0; hwl_level = '0; hwl_start = '0; hwl_end = '0; hwl_count = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_pc", pc, 32'h100);
        chk("reset_active", 32'(hwl_active), 32'h0);
        chk("reset_err", 32'(hwl_err), 32'h0);
        chk("reset_backedge", 32'(hwl_backedge), 32'h0);
        chk("reset_zflag", 32'(pc_hwl_end_zero_flag), 32'h0);
        chk("reset_iter", hwl_iter_count, 32'h0);

        // Sequential, stall, redirect alignment and wrap-around
        for (int i = 0; i < 9; i++) begin
            stall          = tbl[i].stall;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            tick();
            chk($sformatf("vec%0d_pc", i), pc, tbl[i].exp_pc);
        end
        stall = 1'b0; redirect_valid = 1'b0;

        // Single loop, count 3
        arm(1'b0, 32'h20, 32'h28, 16'd3);
        tick();
        hwl_set = 1'b0;
        chk("a_active_set", 32'(hwl_active), 32'h1);
        chk("a_pc0", pc, exp_a[0]);
        bcnt = 0;
        for (int k = 1; k < 13; k++) begin
            bcnt += int'(hwl_backedge);
            tick();
            chk($sformatf("a_pc%0d", k), pc, exp_a[k]);
        end
        chk("a_backedges", 32'(bcnt), 32'd2);
        chk("a_active_exit", 32'(hwl_active), 32'h0);
        chk("a_iter", hwl_iter_count, ITER_AFTER_A);

        // Nested loops sharing an end address; inner re-armed at 0x2C
        arm(1'b1, 32'h2C, 32'h38, 16'd2);
        redirect_valid = 1'b1; redirect_pc = 32'h2C;
        tick();
        redirect_valid = 1'b0;
        hwl_level = 1'b0; hwl_start = 32'h30; hwl_end = 32'h38; hwl_count = 16'd2;
        n30 = 0; n2c = 0;
        for (int c = 0; c < 60 && pc != 32'h3C; c++) begin
            hwl_set = (pc == 32'h2C);
            if (pc == 32'h2C) n2c++;
            if (pc == 32'h30) n30++;
            tick();
        end
        hwl_set = 1'b0;
        chk("b_exit_pc", pc, 32'h3C);
        chk("b_inner_iters", 32'(n30), 32'd4);
        chk("b_outer_iters", 32'(n2c), 32'd2);
        chk("b_active_exit", 32'(hwl_active), 32'h0);

        // Zero-trip loop body is flagged and never back-edges
        chk("c_zflag_3c", 32'(pc_hwl_end_zero_flag), 32'h0);
        arm(1'b0, 32'h40, 32'h48, 16'd0);
        tick();
        hwl_set = 1'b0;
        chk("c_pc40", pc, 32'h40);
        chk("c_zflag_40", 32'(pc_hwl_end_zero_flag), 32'h1);
        chk("c_active", 32'(hwl_active), 32'h0);
        tick();
        chk("c_zflag_44", 32'(pc_hwl_end_zero_flag), 32'h1);
        tick();
        chk("c_pc48", pc, 32'h48);
        chk("c_zflag_48", 32'(pc_hwl_end_zero_flag), 32'h1);
        chk("c_backedge_48", 32'(hwl_backedge), 32'h0);
        tick();
        chk("c_pc4c", pc, 32'h4C);
        chk("c_zflag_4c", 32'(pc_hwl_end_zero_flag), 32'h0);

        // Stall and redirect at the loop end leave the trip count untouched
        arm(1'b0, 32'h60, 32'h64, 16'd3);
        redirect_valid = 1'b1; redirect_pc = 32'h60;
        tick();
        hwl_set = 1'b0; redirect_valid = 1'b0;
        chk("d_pc60", pc, 32'h60);
        tick();
        stall = 1'b1;
        #1;
        chk("d_stall_backedge", 32'(hwl_backedge), 32'h0);
        tick();
        chk("d_stall_pc1", pc, 32'h64);
        tick();
        chk("d_stall_pc2", pc, 32'h64);
        stall = 1'b0;
        #1;
        chk("d_unstall_backedge", 32'(hwl_backedge), 32'h1);
        tick();
        chk("d_back_pc", pc, 32'h60);
        tick();
        chk("d_end_pc", pc, 32'h64);
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        #1;
        chk("d_redir_backedge", 32'(hwl_backedge), 32'h0);
        tick();
        chk("d_redir_pc", pc, 32'h200);
        redirect_pc = 32'h60;
        tick();
        redirect_valid = 1'b0;
        chk("d_resume_pc0", pc, exp_d[0]);
        for (int k = 1; k < 5; k++) begin
            tick();
            chk($sformatf("d_resume_pc%0d", k), pc, exp_d[k]);
        end
        chk("d_active_exit", 32'(hwl_active), 32'h0);

        // Illegal configurations are rejected and latch the error flag
        arm(1'b1, 32'h400, 32'h404, 16'd5);
        tick();
        chk("e_active_ok", 32'(hwl_active), 32'h2);
        chk("e_err_ok", 32'(hwl_err), 32'h0);
        arm(1'b1, 32'h50, 32'h40, 16'd2);
        tick();
        chk("e_err_order", 32'(hwl_err), 32'h1);
        chk("e_active_order", 32'(hwl_active), 32'h2);
        arm(1'b0, 32'h52, 32'h60, 16'd2);
        tick();
        hwl_set = 1'b0;
        chk("e_active_align", 32'(hwl_active), 32'h2);
        repeat (2) tick();
        chk("e_err_sticky", 32'(hwl_err), 32'h1);

        // Reset asserted mid-loop takes effect immediately
        redirect_valid = 1'b1; redirect_pc = 32'h400;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        chk("f_loop_pc", pc, 32'h400);
        #2;
        rst_n = 1'b0;
        #1;
        chk("f_rst_pc", pc, 32'h100);
        chk("f_rst_err", 32'(hwl_err), 32'h0);
        chk("f_rst_active", 32'(hwl_active), 32'h0);
        chk("f_rst_iter", hwl_iter_count, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("f_release_pc", pc, 32'h104);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen_hwl.md
Name: pc_gen_hwl

Overview:
- Program-counter generation stage with zero-overhead hardware-loop (HWL) control.
- Sits directly upstream of instruction fetch and drives its pc and pc_hwl_end_zero_flag inputs.
- Next-PC sources: sequential increment, branch/jump redirect from execute, and loop back-edges from up to HWL_LEVELS nested loops armed by decode.
- Raises pc_hwl_end_zero_flag while a zero-trip loop body is being walked, so fetch substitutes NOPs.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- HWL_LEVELS, 2, number of loop levels; level 0 is innermost and has highest priority.
- COUNT_W, 16, width of each loop trip counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold PC and loop counters this cycle
- redirect_valid  in  1  taken branch/jump
- redirect_pc  in  32  redirect target; bits [1:0] forced to 0
- hwl_set  in  1  arm a loop level (one-cycle pulse from decode)
- hwl_level  in  $clog2(HWL_LEVELS)  level being armed
- hwl_start  in  32  first body instruction address
- hwl_end  in  32  last body instruction address
- hwl_count  in  COUNT_W  trip count
- pc  out  32  current fetch PC (registered)
- pc_hwl_end_zero_flag  out  1  current pc lies in a zero-trip loop body
- hwl_active  out  HWL_LEVELS  per-level armed status
- hwl_backedge  out  1  back-edge selected for the next PC this cycle
- hwl_err  out  1  sticky: illegal loop configuration
- hwl_iter_count  out  32  back-edge counter (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC; all per-level start/end/count cleared; active=0; skip=0; all outputs 0 except pc.
- Per-level state: start, end, count, active, skip.
- Next-PC priority when stall=0: redirect_valid, then HWL back-edge, then pc+4. pc updates on the next clock edge (1-cycle latency).
- When stall=1: pc, count, active and skip hold. hwl_backedge=0.
- Back-edge scan, levels 0..HWL_LEVELS-1, applied only when stall=0 and redirect_valid=0. For each level with active=1 and pc==end:
  - count>1: count decrements. The first such level in scan order selects next=start and hwl_backedge=1, and the scan stops.
  - count==1: count becomes 0 and active clears; the scan continues to outer levels. Nested loops sharing an end address retire inner first, then the outer level back-edges in the same cycle.
- redirect_valid=1: loop state untouched, no decrement, even if pc==end.
- hwl_set (accepted even when stall=1):
  - Loads the level. count>0: active=1, skip=0. count==0: active=0, skip=1.
  - hwl_set wins over a same-cycle back-edge or retire on the same level; that level does not back-edge this cycle.
- Illegal hwl_set: hwl_end < hwl_start, or start/end not word-aligned.
  - Level is not armed.
  - hwl_err sets and stays set until reset.
- pc_hwl_end_zero_flag: combinational. 1 iff any level has skip=1 and start <= pc <= end.
- Skip clears when a non-stalled cycle has pc==end of that level, or on a redirect to an address outside [start,end].
- Wrap-around: pc+4 wraps modulo 2^32. The count decrement never goes below 0.

Optional Feature:
- Macro HWL_PERF_CNT_EN.
- Defined: hwl_iter_count is a 32-bit register, reset to 0, incremented on every cycle with hwl_backedge=1. It wraps at 2^32.
- Undefined: hwl_iter_count is tied to 0 and no counter logic is generated.

Test Plan:
- Reset with RESET_PC=0x100, release, stall=0 for 3 cycles -> pc sequence 0x100, 0x104, 0x108, 0x10C.
- hwl_set level0 start=0x20, end=0x28, count=3 while pc runs from 0x10 -> pc visits 0x20..0x28 three times, then 0x2C. hwl_backedge pulses twice (also hwl_iter_count=2 with the macro). hwl_active[0] clears when leaving 0x28 the third time.
- Nested loops: level0 {0x30, 0x38, 2} inside level1 {0x2C, 0x38, 2}, shared end -> inner body 0x30..0x38 executes 4 times total, 0x2C twice, exits to 0x3C.
- hwl_set count=0 with start=0x40, end=0x48 -> pc_hwl_end_zero_flag=1 for pc 0x40, 0x44, 0x48. Flag is 0 at 0x4C. No back-edge.
- redirect_valid with redirect_pc=0x203 while pc==end of an active loop -> next pc=0x200, count unchanged. stall=1 at pc==end -> pc holds and no decrement until stall drops.
- hwl_set with start=0x50, end=0x40 -> hwl_err=1 and stays 1; hwl_active unchanged. Assert rst_n=0 mid-loop -> pc=RESET_PC and hwl_err=0 immediately.
